// File: rtl/gray_mac_sequencer.sv
// Time-multiplexed RGB-to-grayscale engine: one shared 8x8 multiplier and an 18-bit accumulator, 4 cycles per pixel.
// Optional `define ROUND_EN starts the accumulator at 128 (round-half-up) instead of 0 (truncate).
module gray_mac_sequencer #(
  parameter logic [7:0] W_R   = 8'd77,
  parameter logic [7:0] W_G   = 8'd150,
  parameter logic [7:0] W_B   = 8'd29,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       R,
  input  logic [7:0]       G,
  input  logic [7:0]       B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       gray,
  output logic             busy,
  output logic [CNT_W-1:0] pix_count
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_R,
    MUL_G,
    MUL_B,
    DONE
  } state_t;

`ifdef ROUND_EN
  localparam logic [17:0] ACC_INIT = 18'd128;
`else
  localparam logic [17:0] ACC_INIT = 18'd0;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_r;
  logic [7:0]       r_g;
  logic [7:0]       r_b;
  logic [17:0]      r_acc;
  logic [7:0]       r_gray;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_pix_count;

  logic [7:0]       w_operand;
  logic [7:0]       w_weight;
  logic [15:0]      w_product;
  logic [17:0]      w_acc_next;
  logic [7:0]       w_gray_sat;
  logic             w_in_fire;
  logic             w_out_fire;

  assign in_ready   = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_operand    = 8'd0;
    w_weight     = 8'd0;
    case (r_state)
      IDLE: begin
        if (w_in_fire) w_state_next = MUL_R;
      end
      MUL_R: begin
        w_operand    = r_r;
        w_weight     = W_R;
        w_state_next = MUL_G;
      end
      MUL_G: begin
        w_operand    = r_g;
        w_weight     = W_G;
        w_state_next = MUL_B;
      end
      MUL_B: begin
        w_operand    = r_b;
        w_weight     = W_B;
        w_state_next = DONE;
      end
      DONE: begin
        if (out_ready) w_state_next = in_valid ? MUL_R : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_product  = 16'(w_operand) * 16'(w_weight);
  assign w_acc_next = r_acc + 18'(w_product);
  // Only overridden weights can push the sum past 255 << 8.
  assign w_gray_sat = (|w_acc_next[17:16]) ? 8'hFF : w_acc_next[15:8];

  // NOTE: state uses non-blocking assignments and an async reset; every register, channel latches included, resets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_r         <= 8'd0;
      r_g         <= 8'd0;
      r_b         <= 8'd0;
      r_acc       <= 18'd0;
      r_gray      <= 8'd0;
      r_out_valid <= 1'b0;
      r_pix_count <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_in_fire) begin
        r_r   <= R;
        r_g   <= G;
        r_b   <= B;
        r_acc <= ACC_INIT;
      end else if (r_state inside {MUL_R, MUL_G, MUL_B}) begin
        r_acc <= w_acc_next;
      end

      if (r_state == MUL_B) begin
        r_gray      <= w_gray_sat;
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end

      if (w_out_fire) r_pix_count <= r_pix_count + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign gray      = r_gray;
  assign busy      = (r_state != IDLE);
  assign pix_count = r_pix_count;

endmodule

// File: doc/gray_mac_sequencer.md
Name: gray_mac_sequencer

Overview:
Time-multiplexed RGB-to-grayscale engine for low-area builds. It shares one 8x8 multiplier and one accumulator across the R, G and B channels under FSM control, computing gray = (R*W_R + G*W_G + B*W_B) >> 8. Pixels arrive on a valid/ready input stream from the pixel fetch stage and leave on a valid/ready output stream to the downstream image buffer. Each pixel takes 4 cycles.

Parameters:
W_R, 77, red weight (8-bit unsigned)
W_G, 150, green weight (8-bit unsigned)
W_B, 29, blue weight (8-bit unsigned)
CNT_W, 16, width of the completed-pixel counter

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel this cycle
R  in  8  red channel, sampled on input handshake
G  in  8  green channel, sampled on input handshake
B  in  8  blue channel, sampled on input handshake
out_valid  out  1  gray result valid
out_ready  in  1  downstream accepts result
gray  out  8  grayscale result, stable while out_valid=1
busy  out  1  high in any state other than IDLE
pix_count  out  CNT_W  count of completed output handshakes

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=0, channel regs=0, gray=0, out_valid=0, busy=0, pix_count=0. in_ready=1 from the first cycle after reset. Asserting reset mid-pixel discards that pixel; it produces no output.
- Datapath: one 8x8 unsigned multiplier. Its operand is muxed from the latched channel selected by state, times the matching weight. acc is 18 bits. The full product is zero-extended and added each MUL cycle. Max acc is 255*765+128 = 195203, so it never wraps.
- States: IDLE, MUL_R, MUL_G, MUL_B, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch R/G/B, set acc=0 (or 128 with ROUND_EN), and go to MUL_R.
- MUL_R, MUL_G, MUL_B: each edge does acc += channel*weight and advances one state. in_ready=0.
- MUL_B edge: gray = saturate(acc_next[17:8]) to 255, out_valid=1, go to DONE.
- Latency: if the handshake is at edge E0, out_valid is visible after E3.
- DONE: out_valid=1 and gray is held until out_ready=1.
- On the out handshake: pix_count += 1, wrapping to 0 at 2^CNT_W.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Simultaneous out handshake and in_valid in DONE: accept the new pixel, go directly to MUL_R, and clear out_valid. Sustained throughput is 1 pixel per 4 cycles.
- Out handshake in DONE without in_valid: go to IDLE and clear out_valid.
- out_valid never drops without a handshake. gray changes only on the MUL_B edge.
- Input changes while not in IDLE/DONE-accept are ignored, because the channels are latched.
- busy = (state != IDLE).
- Default weights sum to 256, so saturation is only reachable with overridden weights.

Optional Feature:
ROUND_EN. When defined, acc is initialised to 128 on accept, giving round-half-up instead of truncation. When undefined, acc is initialised to 0 (truncation). No port or latency change either way.

Test Plan:
- Reset, then R=255,G=255,B=255 with out_ready=1 -> out_valid exactly 3 edges after accept, gray=255, pix_count=1.
- R=100,G=50,B=200 -> acc=21000, gray=82 (also 82 with ROUND_EN). R=255,G=0,B=0 -> gray=76; with ROUND_EN gray=77.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> gray and out_valid held, in_ready=0, pix_count unchanged. Then raise out_ready with in_valid=1 -> same-cycle accept, next result 4 cycles later.
- Back-to-back stream of 8 pixels with in_valid and out_ready always 1 -> one result every 4 cycles, pix_count=8. With CNT_W=3 override, pix_count wraps to 0.
- Override W_R=W_G=W_B=255 with R=G=B=255 -> acc=195075, gray saturates to 255.
- Assert rst_n=0 during MUL_G -> all outputs reset immediately. After release there is no out_valid for the aborted pixel, pix_count=0, in_ready=1.
